seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
// - Serial pattern generator: transmit end of the overlapping sequence-detector path.
// - Takes a right-aligned bit pattern, a length, a repeat count and an inter-repeat gap
//   through a valid/ready start handshake.
// - Emits the pattern MSB-first, one bit per clock, on a single serial line.
// - Drives detector inputs in system loopback; also serves as the bench stimulus source.
// PARAMETERS
// - MAX_LEN   8                    widest pattern supported (bits)
// - LEN_W     $clog2(MAX_LEN+1)    width of len_in
// - REP_W     4                    width of rep_in (repeat count)
// - GAP_W     4                    width of gap_in (idle cycles between repeats)
// - IDLE_LVL  1'b0                 serial line level when no bit is driven
// PORTS
// - clk          in   1        single clock, rising edge
// - rst          in   1        synchronous reset, active-high
// - start_valid  in   1        config valid
// - start_ready  out  1        block can accept config
// - pat_in       in   MAX_LEN  pattern, right-aligned; bit len_in-1 sent first
// - len_in       in   LEN_W    pattern length in bits
// - rep_in       in   REP_W    number of pattern repetitions
// - gap_in       in   GAP_W    idle cycles between repetitions (0 = back-to-back)
// - abort        in   1        terminate transfer in progress
// - Out          out  1        serial data bit (registered)
// - out_valid    out  1        Out carries a pattern bit this cycle (registered)
// - busy         out  1        transfer in progress (SHIFT or GAP)
// - done         out  1        one-cycle end-of-transfer pulse
// - err          out  1        qualifies done: bad config or abort
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high (clk, rst).
// - Reset values: Out=IDLE_LVL, out_valid=0, busy=0, done=0, err=0, start_ready=0,
//   state=IDLE.
// - start_ready=1 only in IDLE with rst low. start_valid held through reset is not
//   accepted until the first post-reset IDLE cycle.
// - Accept when start_valid&&start_ready. pat/len/rep/gap are captured at acceptance;
//   later input changes are ignored until the next acceptance.
// - States:
//   - IDLE  -> SHIFT on valid accept; -> DONE (err=1) on accept with len_in==0,
//     len_in>MAX_LEN or rep_in==0.
//   - SHIFT -> drives bit[bit_idx], out_valid=1, bit_idx counts len-1 down to 0.
//     At bit 0: -> GAP if reps remain and gap>0; -> SHIFT (reload) if reps remain and
//     gap==0; else -> DONE.
//   - GAP   -> Out=IDLE_LVL, out_valid=0 for exactly gap cycles, then -> SHIFT.
//   - DONE  -> done=1 for exactly one cycle, start_ready=0, then -> IDLE.
// - Latency: first bit on Out the cycle after acceptance.
// - Timing: SHIFT+GAP span = len*rep + gap*(rep-1) cycles; done follows on the next
//   cycle.
// - Back-to-back repeats (gap=0) give a gapless stream, so overlapping detection works
//   across repeat boundaries.
// - err is meaningful only with done; it is 0 on normal completion.
// - abort in SHIFT/GAP: next cycle DONE with err=1, out_valid=0, Out=IDLE_LVL.
//   abort in IDLE/DONE is ignored. A bit in flight in the abort cycle still completes.
// - rst mid-transfer: next cycle all outputs at reset values; no done pulse.
// - busy=1 exactly while state is SHIFT or GAP.
// - Counters: bit_idx LEN_W, rep_left REP_W, gap_left GAP_W. All decrement;
//   none may wrap.
// STRUCTURE
// - seq_gen_pkg: state enum {IDLE,SHIFT,GAP,DONE} (2-bit), default-width localparams,
//   IDLE_LVL default.
// - Sub-module seq_gen_cnt: loadable down-counter with zero flag, instanced for
//   bit_idx, rep_left, gap_left.
// - Top: FSM + registered output stage only.
// TESTING
// - pat=6'b101010,len=6,rep=1,gap=0 -> Out 1,0,1,0,1,0 with out_valid=1 for 6 cycles;
//   done=1,err=0 on cycle 7.
// - same pattern, rep=3,gap=0 -> 18 contiguous valid bits (101010 x3); done on
//   cycle 19; start_ready back on cycle 20.
// - pat=3'b110,len=3,rep=2,gap=2 -> out_valid 1,1,1,0,0,1,1,1; Out 1,1,0,0,0,1,1,0;
//   done on cycle 9.
// - abort asserted during 3rd bit of len=6 -> next cycle out_valid=0, done=1, err=1;
//   IDLE/start_ready=1 the cycle after.
// - len_in=0 (also len_in=9, rep_in=0) -> no out_valid; done=1,err=1 the cycle after
//   accept.
// - rst pulsed mid-SHIFT with start_valid held high -> outputs at reset values, no done;
//   accept only after rst drops.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the serial pattern generator.
package seq_gen_pkg;

  localparam int unsigned MAX_LEN_DEF  = 8;
  localparam int unsigned LEN_W_DEF    = $clog2(MAX_LEN_DEF + 1);
  localparam int unsigned REP_W_DEF    = 4;
  localparam int unsigned GAP_W_DEF    = 4;
  localparam logic        IDLE_LVL_DEF = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_gen_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement and it never wraps below zero.
module seq_gen_cnt
  import seq_gen_pkg::*;
#(
  parameter int unsigned W = LEN_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero_c
);

  assign zero_c = (value == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && !zero_c) begin
      value <= value - W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: emits a captured pattern MSB-first, repeated with optional idle gaps.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned MAX_LEN  = MAX_LEN_DEF,
  parameter int unsigned LEN_W    = $clog2(MAX_LEN + 1),
  parameter int unsigned REP_W    = REP_W_DEF,
  parameter int unsigned GAP_W    = GAP_W_DEF,
  parameter logic        IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic [REP_W-1:0]   rep_in,
  input  logic [GAP_W-1:0]   gap_in,
  input  logic               abort,
  output logic               Out,
  output logic               out_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [GAP_W-1:0]   gap_q;

  logic [LEN_W-1:0]   bit_idx, bit_load_val;
  logic [REP_W-1:0]   rep_left, rep_load_val;
  logic [GAP_W-1:0]   gap_left, gap_load_val;
  logic               bit_zero, rep_zero, gap_zero;
  logic               bit_load, bit_dec, rep_load, rep_dec, gap_load, gap_dec;

  logic               accept, bad_cfg, capture;
  logic               err_d, out_d, out_valid_d;
  logic [MAX_LEN-1:0] sel_pat;
  logic [LEN_W-1:0]   sel_idx;
  logic               unused_cnt;

  assign start_ready  = (state_q == IDLE) && !rst;
  assign accept       = start_valid && start_ready;
  assign bad_cfg      = (len_in == '0) || (len_in > LEN_W'(MAX_LEN)) || (rep_in == '0);
  assign rep_load_val = rep_in - REP_W'(1);
  assign gap_load_val = gap_q - GAP_W'(1);
  assign unused_cnt   = &{1'b0, rep_left, gap_left};

  seq_gen_cnt #(.W(LEN_W)) u_bit_cnt (
    .clk(clk), .rst(rst), .load(bit_load), .load_val(bit_load_val), .dec(bit_dec),
    .value(bit_idx), .zero_c(bit_zero)
  );

  seq_gen_cnt #(.W(REP_W)) u_rep_cnt (
    .clk(clk), .rst(rst), .load(rep_load), .load_val(rep_load_val), .dec(rep_dec),
    .value(rep_left), .zero_c(rep_zero)
  );

  seq_gen_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .rst(rst), .load(gap_load), .load_val(gap_load_val), .dec(gap_dec),
    .value(gap_left), .zero_c(gap_zero)
  );

  // Next state plus the value each output register takes on the same edge
  always_comb begin
    state_d      = state_q;
    err_d        = 1'b0;
    out_valid_d  = 1'b0;
    capture      = 1'b0;
    bit_load     = 1'b0;
    bit_dec      = 1'b0;
    rep_load     = 1'b0;
    rep_dec      = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
    bit_load_val = len_q - LEN_W'(1);
    sel_pat      = pat_q;
    sel_idx      = len_q - LEN_W'(1);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          capture = 1'b1;
          if (bad_cfg) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d      = SHIFT;
            bit_load     = 1'b1;
            bit_load_val = len_in - LEN_W'(1);
            rep_load     = 1'b1;
            sel_pat      = pat_in;
            sel_idx      = len_in - LEN_W'(1);
            out_valid_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (!bit_zero) begin
          bit_dec     = 1'b1;
          sel_idx     = bit_idx - LEN_W'(1);
          out_valid_d = 1'b1;
        end else if (!rep_zero) begin
          rep_dec = 1'b1;
          if (gap_q != '0) begin
            state_d  = GAP;
            gap_load = 1'b1;
          end else begin
            bit_load    = 1'b1;
            out_valid_d = 1'b1;
          end
        end else begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (gap_zero) begin
          state_d     = SHIFT;
          bit_load    = 1'b1;
          out_valid_d = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_d = out_valid_d ? |(sel_pat & (MAX_LEN'(1) << sel_idx)) : IDLE_LVL;
  end

  // State, captured config and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      Out       <= IDLE_LVL;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      Out       <= out_d;
      out_valid <= out_valid_d;
      busy      <= (state_d == SHIFT) || (state_d == GAP);
      done      <= (state_d == DONE);
      err       <= err_d;
      if (capture) begin
        pat_q <= pat_in;
        len_q <= len_in;
        gap_q <= gap_in;
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed cases plus randomized transfers vs. a slot-list model.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic [3:0] rep_in;
  logic [3:0] gap_in;
  logic       abort;
  logic       out_bit;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit v;
    bit b;
  } slot_t;

  slot_t exp_q[$];

  always #5 clk = ~clk;

  seq_pattern_gen dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .pat_in(pat_in), .len_in(len_in), .rep_in(rep_in), .gap_in(gap_in),
    .abort(abort), .Out(out_bit), .out_valid(out_valid), .busy(busy),
    .done(done), .err(err)
  );

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a config and take the acceptance edge; scramble inputs afterwards
  task automatic do_accept(input logic [7:0] pat, input int len, input int rep, input int gap);
    pat_in      = pat;
    len_in      = 4'(len);
    rep_in      = 4'(rep);
    gap_in      = 4'(gap);
    start_valid = 1'b1;
    #1;
    check_eq("ready_at_accept", start_ready, 1'b1);
    tick();
    start_valid = 1'b0;
    pat_in      = 8'($urandom);
    len_in      = 4'($urandom);
    rep_in      = 4'($urandom);
    gap_in      = 4'($urandom);
  endtask

  // Model: list of line slots for the whole transfer, then the done cycle
  task automatic check_body(input logic [7:0] pat, input int len, input int rep, input int gap,
                            input int abort_at);
    bit bad;
    bit aborted;
    int n;
    exp_q.delete();
    bad = (len == 0) || (len > 8) || (rep == 0);
    if (!bad) begin
      for (int r = 0; r < rep; r++) begin
        for (int i = len - 1; i >= 0; i--) exp_q.push_back('{1'b1, pat[i]});
        if (r < rep - 1) for (int g = 0; g < gap; g++) exp_q.push_back('{1'b0, 1'b0});
      end
    end
    n = exp_q.size();
    aborted = 1'b0;
    if (abort_at > 0 && abort_at <= n) begin
      n = abort_at;
      aborted = 1'b1;
    end
    for (int c = 1; c <= n; c++) begin
      check_eq("out_valid", out_valid, exp_q[c-1].v);
      check_eq("out", out_bit, exp_q[c-1].v ? exp_q[c-1].b : 1'b0);
      check_eq("busy", busy, 1'b1);
      check_eq("done_early", done, 1'b0);
      if (c == abort_at) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    check_eq("done_pulse", done, 1'b1);
    check_eq("err", err, bad || aborted);
    check_eq("valid_at_done", out_valid, 1'b0);
    check_eq("out_at_done", out_bit, 1'b0);
    check_eq("busy_at_done", busy, 1'b0);
    check_eq("ready_at_done", start_ready, 1'b0);
    tick();
    check_eq("done_clear", done, 1'b0);
    check_eq("ready_after", start_ready, 1'b1);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      abort = 1'($urandom);
      #1;
      check_eq("idle_valid", out_valid, 1'b0);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_ready", start_ready, 1'b1);
      tick();
      abort = 1'b0;
      check_eq("idle_done", done, 1'b0);
    end
  endtask

  task automatic check_reset_vals();
    check_eq("rst_out", out_bit, 1'b0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_ready", start_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start_valid = 1'b1;
    abort       = 1'b0;
    pat_in      = 8'h2A;
    len_in      = 4'd6;
    rep_in      = 4'd1;
    gap_in      = 4'd0;
    repeat (3) tick();
    check_reset_vals();
    rst = 1'b0;

    // start_valid held through reset is taken on the first IDLE cycle
    do_accept(8'b101010, 6, 1, 0);
    check_body(8'b101010, 6, 1, 0, 0);
    do_accept(8'b101010, 6, 3, 0);
    check_body(8'b101010, 6, 3, 0, 0);
    do_accept(8'b110, 3, 2, 2);
    check_body(8'b110, 3, 2, 2, 0);
    do_accept(8'b101010, 6, 1, 0);
    check_body(8'b101010, 6, 1, 0, 3);
    do_accept(8'hFF, 0, 1, 0);
    check_body(8'hFF, 0, 1, 0, 0);
    do_accept(8'hFF, 9, 1, 0);
    check_body(8'hFF, 9, 1, 0, 0);
    do_accept(8'hFF, 4, 0, 0);
    check_body(8'hFF, 4, 0, 0, 0);
    idle_cycles(2);

    // Reset mid-SHIFT with start_valid held high
    do_accept(8'hB5, 8, 2, 1);
    repeat (3) begin
      check_eq("pre_rst_valid", out_valid, 1'b1);
      tick();
    end
    rst         = 1'b1;
    start_valid = 1'b1;
    pat_in      = 8'h0D;
    len_in      = 4'd4;
    rep_in      = 4'd2;
    gap_in      = 4'd1;
    tick();
    check_reset_vals();
    tick();
    check_reset_vals();
    rst = 1'b0;
    do_accept(8'h0D, 4, 2, 1);
    check_body(8'h0D, 4, 2, 1, 0);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] pat;
      int len, rep, gap, span, ab;
      pat = 8'($urandom);
      len = $urandom_range(1, 8);
      rep = $urandom_range(1, 4);
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(9, 15);
      if ($urandom_range(0, 9) == 0) rep = 0;
      span = len * rep + gap * (rep - 1);
      ab = 0;
      if (len <= 8 && rep > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, span);
      idle_cycles($urandom_range(0, 2));
      do_accept(pat, len, rep, gap);
      check_body(pat, len, rep, gap, ab);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
